apb_master_param: RTL and testbench

Parametrised APB4 bridge master sitting between the CPU load/store unit and the peripheral slaves. It replaces the fixed 5-slave master with:
- a configurable slave count and address map;
- PSTRB byte strobes;
- PSLVERR propagation;
- an unmapped-address error response;
- an ACCESS-phase timeout;
- back-to-back transfers with no IDLE bubble.

---
 rtl/apb_master_param_if.sv | 61 ++++++
 rtl/apb_master_param.sv | 147 ++++++++++++++
 tb/tb_apb_master_param.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_param_if.sv
// -----------------------------------------------------------------------------
// apb_master_param_if
// Bundles the APB4 bus (master <-> peripheral slaves) and the CPU-side request
// port of the APB bridge master.
//
// Signals:
//   APB side : PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL (driven by master)
//              PRDATA, PREADY, PSLVERR            (driven by slaves, per channel)
//   CPU side : transfer, write, addr, wdata, strb  (request, driven by requester)
//              ready, rdata, error, busy           (completion, driven by master)
//
// Handshake: a request is presented with transfer=1 and is taken on the clock
// edge where the master is IDLE or completing (ready=1); ready is a one-cycle
// completion pulse and rdata/error are only meaningful while ready=1.
//
// Modports:
//   master : the bridge master view
//   slave  : the view of everything around it (requester + APB slaves)
// -----------------------------------------------------------------------------
interface apb_master_param_if #(
    parameter int NUM_SLAVES = 8,
    parameter int DATA_W     = 32
);
    localparam int STRB_W = DATA_W / 8;

    // APB bus
    logic [31:0]                  PADDR;
    logic                         PWRITE;
    logic                         PENABLE;
    logic [DATA_W-1:0]            PWDATA;
    logic [STRB_W-1:0]            PSTRB;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    // CPU request / completion
    logic                         transfer;
    logic                         write;
    logic [31:0]                  addr;
    logic [DATA_W-1:0]            wdata;
    logic [STRB_W-1:0]            strb;
    logic                         ready;
    logic [DATA_W-1:0]            rdata;
    logic                         error;
    logic                         busy;

    modport master (
        output PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
        input  PRDATA, PREADY, PSLVERR,
        input  transfer, write, addr, wdata, strb,
        output ready, rdata, error, busy
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
        output PRDATA, PREADY, PSLVERR,
        output transfer, write, addr, wdata, strb,
        input  ready, rdata, error, busy
    );
endinterface

// File: rtl/apb_master_param.sv
// -----------------------------------------------------------------------------
// apb_master_param
// Parametrised APB4 bridge master between the CPU load/store unit and
// NUM_SLAVES peripheral slaves. Slave i owns the window
// BASE_ADDR + (i << SLOT_BITS) .. +2^SLOT_BITS-1. Addresses outside all windows
// complete immediately with error=1 and never assert PSEL. An ACCESS phase that
// sees no PREADY for TIMEOUT cycles is terminated with error=1 (TIMEOUT=0
// disables this). A request presented on the completion cycle goes straight to
// SETUP with no IDLE bubble.
//
// Ports:
//   PCLK        clock
//   PRESETn     asynchronous active-low reset
//   bus         apb_master_param_if.master (APB bus + CPU request port)
//   dbg_state_o current FSM state (IDLE=0, SETUP=1, ACCESS=2)
// -----------------------------------------------------------------------------
module apb_master_param #(
    parameter int          NUM_SLAVES = 8,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          SLOT_BITS  = 12,
    parameter int          TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    apb_master_param_if.master      bus,
    output logic [1:0]              dbg_state_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [31:0]       paddr_q,  paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q,  pstrb_d;
    logic              pwrite_q, pwrite_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Address decode, always from the latched address.
    logic [31:0]           off;
    logic [31:0]           slot;
    logic                  mapped;
    logic [NUM_SLAVES-1:0] sel_vec;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;

    assign off    = paddr_q - BASE_ADDR;
    assign slot   = off >> SLOT_BITS;
    assign mapped = (paddr_q >= BASE_ADDR) && (slot < 32'(NUM_SLAVES));

    // Compare against each channel number instead of indexing with slot, so an
    // out-of-range slot can never select anything.
    always_comb begin
        sel_vec   = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_vec[i] = mapped && (slot == 32'(i));
            if (sel_vec[i]) begin
                sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ready = |(bus.PREADY  & sel_vec);
    assign sel_err   = |(bus.PSLVERR & sel_vec);

    logic in_access;
    logic timeout_hit;
    logic done;
    logic load;

    assign in_access   = (state_q == ST_ACCESS);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // An unmapped access completes on its first ACCESS cycle; a mapped one on
    // PREADY or on the last allowed cycle. PREADY wins over a coincident timeout.
    assign done = in_access && (!mapped || sel_ready || timeout_hit);

    // New request is taken from IDLE or on the completion cycle.
    assign load = bus.transfer && ((state_q == ST_IDLE) || done);

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pwrite_d = pwrite_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE:   if (bus.transfer) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (done) state_d = bus.transfer ? ST_SETUP : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase

        if (load) begin
            paddr_d  = bus.addr;
            pwdata_d = bus.wdata;
            pwrite_d = bus.write;
            pstrb_d  = bus.write ? bus.strb : '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pwrite_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pwrite_q <= pwrite_d;
            cnt_q    <= cnt_d;
        end
    end

    // PSEL/PENABLE/busy are decoded from state, so reset drops them at once.
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PENABLE = in_access;
    assign bus.PSEL    = (state_q != ST_IDLE) ? sel_vec : '0;
    assign bus.busy    = (state_q != ST_IDLE);

    assign bus.ready = done;
    assign bus.error = done && (!mapped || !sel_ready || sel_err);
    assign bus.rdata = (done && mapped && sel_ready && !pwrite_q) ? sel_rdata : '0;

    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_apb_master_param.sv
module tb_apb_master_param;
  localparam int NS = 8;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int MAXCYC = 40;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int total;
  int bad;

  apb_master_param_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();

  apb_master_param #(
    .NUM_SLAVES(NS), .DATA_W(DW), .BASE_ADDR(BASE), .SLOT_BITS(12), .TIMEOUT(TO)
  ) dut (
    .PCLK(clk),
    .PRESETn(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: outcome of one transfer from the address map rules.
  task automatic model(input logic [31:0] a, input bit w, input int waits, input bit serr,
                       input logic [31:0] rdv, output int cyc, output bit err,
                       output logic [31:0] rd, output logic [7:0] sel, output int idx);
    longint unsigned slot;
    bit mapped;
    slot   = (a >= BASE) ? (longint'(a) - longint'(BASE)) / 4096 : 0;
    mapped = (a >= BASE) && (slot < NS);
    idx    = mapped ? int'(slot) : -1;
    sel    = mapped ? 8'(1 << slot) : 8'h00;
    if (!mapped) begin
      cyc = 1; err = 1'b1; rd = 0;
    end else if (waits >= TO) begin
      cyc = TO; err = 1'b1; rd = 0;
    end else begin
      cyc = waits + 1; err = serr; rd = w ? 32'h0 : rdv;
    end
  endtask

  // driver tasks
  task automatic launch(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s);
    bus.transfer = 1'b1;
    bus.addr     = a;
    bus.write    = w;
    bus.wdata    = d;
    bus.strb     = s;
  endtask

  // Runs a transfer already presented by launch(); optionally chains the next
  // request on the completion cycle. Returns at a negative edge.
  task automatic run(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                     input int waits, input bit serr, input logic [31:0] rdv,
                     input bit nxt, input logic [31:0] na, input bit nw,
                     input logic [31:0] nd, input logic [3:0] ns);
    int exp_cyc, idx, k;
    bit exp_err, got;
    logic [31:0] exp_rd;
    logic [7:0] exp_sel;
    logic [3:0] exp_strb;
    model(a, w, waits, serr, rdv, exp_cyc, exp_err, exp_rd, exp_sel, idx);
    exp_strb = w ? s : 4'h0;

    @(posedge clk);
    #1;
    // scramble the request side: it must be ignored after latching
    bus.transfer = 1'b0;
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
    bus.write    = 1'($urandom);
    bus.strb     = 4'($urandom);
    bus.PREADY   = '1;
    @(negedge clk);
    check("setup_psel",    64'(bus.PSEL), 64'(exp_sel));
    check("setup_penable", 64'(bus.PENABLE), 64'(0));
    check("setup_busy",    64'(bus.busy), 64'(1));
    check("setup_ready",   64'(bus.ready), 64'(0));
    check("setup_paddr",   64'(bus.PADDR), 64'(a));
    check("setup_pwrite",  64'(bus.PWRITE), 64'(w));
    check("setup_pwdata",  64'(bus.PWDATA), 64'(d));
    check("setup_pstrb",   64'(bus.PSTRB), 64'(exp_strb));

    k = 0;
    got = 1'b0;
    while (!got && k < MAXCYC) begin
      @(posedge clk);
      k++;
      #1;
      for (int i = 0; i < NS; i++) begin
        if (i == idx) begin
          bus.PREADY[i]  = (k > waits);
          bus.PSLVERR[i] = serr;
          bus.PRDATA[i*DW +: DW] = rdv;
        end else begin
          bus.PREADY[i]  = 1'($urandom);
          bus.PSLVERR[i] = 1'($urandom);
          bus.PRDATA[i*DW +: DW] = $urandom;
        end
      end
      @(negedge clk);
      check("access_penable", 64'(bus.PENABLE), 64'(1));
      check("access_psel",    64'(bus.PSEL), 64'(exp_sel));
      check("access_pstrb",   64'(bus.PSTRB), 64'(exp_strb));
      if (bus.ready === 1'b1) got = 1'b1;
    end
    check("done_cycles", 64'(k), 64'(exp_cyc));
    check("done_error",  64'(bus.error), 64'(exp_err));
    check("done_rdata",  64'(bus.rdata), 64'(exp_rd));

    if (nxt) begin
      launch(na, nw, nd, ns);
    end else begin
      bus.transfer = 1'b0;
      @(posedge clk);
      #1;
      // a late/stray PREADY in IDLE must not produce a completion
      bus.PREADY  = '1;
      bus.PSLVERR = '1;
      @(negedge clk);
      check("idle_busy",    64'(bus.busy), 64'(0));
      check("idle_psel",    64'(bus.PSEL), 64'(0));
      check("idle_penable", 64'(bus.PENABLE), 64'(0));
      check("idle_ready",   64'(bus.ready), 64'(0));
      check("idle_error",   64'(bus.error), 64'(0));
      check("idle_rdata",   64'(bus.rdata), 64'(0));
      check("idle_paddr",   64'(bus.PADDR), 64'(a));
      bus.PREADY  = '0;
      bus.PSLVERR = '0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int idx;
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, 32'h0FFF_FFFF);
    idx = $urandom_range(0, 9);
    return BASE + 32'(idx) * 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
  endfunction

  function automatic int rand_waits();
    return ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 4);
  endfunction

  initial begin
    logic [31:0] ca, cd, cr, na, nd;
    logic [3:0]  cs, ns;
    bit          cw, nw, ce, b2b;
    int          cwt;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.strb     = '0;
    bus.PRDATA   = '0;
    bus.PREADY   = '0;
    bus.PSLVERR  = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_paddr",   64'(bus.PADDR), 64'(0));
    check("rst_pwdata",  64'(bus.PWDATA), 64'(0));
    check("rst_pstrb",   64'(bus.PSTRB), 64'(0));
    check("rst_pwrite",  64'(bus.PWRITE), 64'(0));
    check("rst_penable", 64'(bus.PENABLE), 64'(0));
    check("rst_psel",    64'(bus.PSEL), 64'(0));
    check("rst_ready",   64'(bus.ready), 64'(0));
    check("rst_busy",    64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write to slave 2, immediate PREADY
    launch(32'h1000_2004, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    run(32'h1000_2004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0, 32'h0,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // 2: read from slave 7 with three wait states
    launch(32'h1000_7010, 1'b0, 32'h5555_AAAA, 4'hF);
    run(32'h1000_7010, 1'b0, 32'h5555_AAAA, 4'hF, 3, 1'b0, 32'h1234_5678,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // 3: unmapped read just past the last window
    launch(32'h1000_8000, 1'b0, 32'h0, 4'h0);
    run(32'h1000_8000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // unmapped read below the base address
    launch(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0);
    run(32'h0FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // 4: write to slave 1 that never answers -> timeout
    launch(32'h1000_1008, 1'b1, 32'hA5A5_5A5A, 4'b1111);
    run(32'h1000_1008, 1'b1, 32'hA5A5_5A5A, 4'b1111, 1000, 1'b0, 32'h0,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // PREADY on exactly the last allowed cycle wins with slave error
    launch(32'h1000_5000, 1'b0, 32'h0, 4'h0);
    run(32'h1000_5000, 1'b0, 32'h0, 4'h0, TO - 1, 1'b1, 32'h0BAD_0BAD,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // 5: back-to-back slave 0 then slave 3
    launch(32'h1000_0010, 1'b1, 32'h0102_0304, 4'b1000);
    run(32'h1000_0010, 1'b1, 32'h0102_0304, 4'b1000, 0, 1'b0, 32'h0,
        1'b1, 32'h1000_3020, 1'b0, 32'h0, 4'hF);
    run(32'h1000_3020, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h7777_8888,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // 6: reset asserted mid-ACCESS with slave 4 waiting
    launch(32'h1000_4000, 1'b0, 32'h0, 4'h0);
    @(posedge clk);
    #1 bus.transfer = 1'b0;
    bus.PREADY = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_psel",    64'(bus.PSEL), 64'(0));
    check("rstmid_penable", 64'(bus.PENABLE), 64'(0));
    check("rstmid_busy",    64'(bus.busy), 64'(0));
    check("rstmid_ready",   64'(bus.ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrel_busy", 64'(bus.busy), 64'(0));
    check("rstrel_psel", 64'(bus.PSEL), 64'(0));
    launch(32'h1000_4004, 1'b0, 32'h0, 4'h0);
    run(32'h1000_4004, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h4444_0004,
        1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // randomized transfers, sometimes chained back-to-back
    ca = rand_addr(); cw = 1'($urandom); cd = $urandom; cs = 4'($urandom);
    launch(ca, cw, cd, cs);
    for (int t = 0; t < 30; t++) begin
      cwt = rand_waits();
      ce  = 1'($urandom);
      cr  = $urandom;
      na = rand_addr(); nw = 1'($urandom); nd = $urandom; ns = 4'($urandom);
      b2b = (t < 29) && ($urandom_range(0, 1) == 1);
      run(ca, cw, cd, cs, cwt, ce, cr, b2b, na, nw, nd, ns);
      ca = na; cw = nw; cd = nd; cs = ns;
      if (!b2b && t < 29) launch(ca, cw, cd, cs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
